// File: rtl/seg7_char_decoder_if.sv
// Scanned 7-segment bus plus decoded-frame outputs of seg7_char_decoder.
// master drives the display bus; slave is the decoder.
interface seg7_char_decoder_if;
  logic [0:6] SEG_in;
  logic [3:0] DIG_in;
  logic [7:0] CHARS;
  logic       frame_valid;
  logic       pat_err;
  logic       dig_err;

  modport master (output SEG_in, DIG_in, input CHARS, frame_valid, pat_err, dig_err);
  modport slave  (input SEG_in, DIG_in, output CHARS, frame_valid, pat_err, dig_err);
endinterface

// File: rtl/seg7_char_decoder.sv
// Debounces a scanned 7-segment bus, decodes each stable digit to a 2-bit character
// and publishes 4-character frames. Define SEG7_DEC_ACTIVE_HIGH_EN for active-high segments.
module seg7_char_decoder #(
  parameter int unsigned STABLE = 4
) (
  input  logic            clk_i,
  input  logic            rst_i,
  seg7_char_decoder_if.slave bus
);

  localparam logic [7:0] STABLE_C = 8'(STABLE);

  typedef enum logic [1:0] {IDLE, COUNT, HELD} state_t;

  state_t     state_q, state_d;
  logic [0:6] seg_q, seg_d;
  logic [3:0] dig_q, dig_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] slot_q, slot_d;
  logic [7:0] chars_q, chars_d;
  logic [3:0] seen_q, seen_d;
  logic       fv_q, fv_d;
  logic       pe_q, pe_d;
  logic       de_q, de_d;

  logic [0:6] seg_in;
  logic [3:0] dig_in;
  logic       multi, onehot, same, acc, legal;
  logic [1:0] code, pos;
  logic [3:0] seen_n;

`ifdef SEG7_DEC_ACTIVE_HIGH_EN
  assign seg_in = ~bus.SEG_in;
`else
  assign seg_in = bus.SEG_in;
`endif
  assign dig_in = bus.DIG_in;

  assign multi  = |(dig_in & (dig_in - 4'd1));
  assign onehot = (dig_in != 4'd0) && !multi;
  assign same   = (seg_in == seg_q) && (dig_in == dig_q);

  always_comb begin
    legal = 1'b1;
    code  = 2'b11;
    case (seg_in)
      7'b1000010: code = 2'b00;
      7'b0110000: code = 2'b01;
      7'b1001111: code = 2'b10;
      7'b1111111: code = 2'b11;
      default:    legal = 1'b0;
    endcase
  end

  always_comb begin
    pos = 2'd0;
    case (dig_in)
      4'b0010: pos = 2'd1;
      4'b0100: pos = 2'd2;
      4'b1000: pos = 2'd3;
      default: pos = 2'd0;
    endcase
  end

  // Run tracking: every accept uses the pair currently on the bus.
  always_comb begin
    state_d = state_q;
    seg_d   = seg_q;
    dig_d   = dig_q;
    cnt_d   = cnt_q;
    acc     = 1'b0;
    if (!onehot) begin
      state_d = IDLE;
      cnt_d   = 8'd0;
    end else if (state_q == COUNT && same) begin
      cnt_d = cnt_q + 8'd1;
      if (cnt_q + 8'd1 == STABLE_C) begin
        acc     = 1'b1;
        state_d = HELD;
      end
    end else if (!(state_q == HELD && same)) begin
      seg_d = seg_in;
      dig_d = dig_in;
      cnt_d = 8'd1;
      if (STABLE_C == 8'd1) begin
        acc     = 1'b1;
        state_d = HELD;
      end else begin
        state_d = COUNT;
      end
    end
  end

  always_comb begin
    slot_d  = slot_q;
    seen_d  = seen_q;
    chars_d = chars_q;
    seen_n  = seen_q;
    fv_d    = 1'b0;
    pe_d    = 1'b0;
    de_d    = multi;
    if (acc) begin
      if (legal) begin
        slot_d[{pos, 1'b0} +: 2] = code;
        seen_n = seen_q | (4'b0001 << pos);
        if (seen_n == 4'hF) begin
          chars_d = slot_d;
          fv_d    = 1'b1;
          seen_d  = 4'h0;
        end else begin
          seen_d = seen_n;
        end
      end else begin
        pe_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      seg_q   <= '1;
      dig_q   <= 4'd0;
      cnt_q   <= 8'd0;
      slot_q  <= 8'hFF;
      seen_q  <= 4'h0;
      chars_q <= 8'hFF;
      fv_q    <= 1'b0;
      pe_q    <= 1'b0;
      de_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      seg_q   <= seg_d;
      dig_q   <= dig_d;
      cnt_q   <= cnt_d;
      slot_q  <= slot_d;
      seen_q  <= seen_d;
      chars_q <= chars_d;
      fv_q    <= fv_d;
      pe_q    <= pe_d;
      de_q    <= de_d;
    end
  end

  assign bus.CHARS       = chars_q;
  assign bus.frame_valid = fv_q;
  assign bus.pat_err     = pe_q;
  assign bus.dig_err     = de_q;

endmodule
